// File: rtl/mem_block_responder.sv
// Main-memory responder for cache block fetches: waits a fixed access latency,
// fills the block one word per cycle from an address-derived pattern, then holds it until req drops.
module mem_block_responder #(
  parameter int way             = 1,
  parameter int block_size_byte = 64,
  parameter int cache_size_byte = 16384,
  parameter int mem_latency     = 10,
  localparam int BOFF  = $clog2(block_size_byte),
  localparam int SETS  = cache_size_byte / (block_size_byte * way),
  localparam int SIDX  = $clog2(SETS),
  localparam int TAG_W = 32 - SIDX - BOFF,
  localparam int BLK_W = block_size_byte * 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [TAG_W-1:0] tag,
  input  logic [SIDX-1:0]  index,
  output logic [BLK_W-1:0] block,
  output logic             block_ready,
  output logic             busy,
  output logic [15:0]      served_count
);

  localparam int WORDS = block_size_byte / 4;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CNT_W = (mem_latency > 1) ? $clog2(mem_latency) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((mem_latency > 0) ? mem_latency - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FILL, S_RESP} state_t;

  state_t             state_q, state_d;
  logic [31:0]        base_q, base_d;
  logic [BLK_W-1:0]   block_q, block_d;
  logic               ready_q, ready_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [15:0]        served_count_q, served_count_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      base_q         <= '0;
      block_q        <= '0;
      ready_q        <= 1'b0;
      cnt_q          <= '0;
      idx_q          <= '0;
      served_count_q <= '0;
    end else begin
      state_q        <= state_d;
      base_q         <= base_d;
      block_q        <= block_d;
      ready_q        <= ready_d;
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      served_count_q <= served_count_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    base_d         = base_q;
    block_d        = block_q;
    ready_d        = ready_q;
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    served_count_d = served_count_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          base_d  = {tag, index, {BOFF{1'b0}}};
          block_d = '0;
          idx_d   = '0;
          if (mem_latency > 0) begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = S_FILL;
          end
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_FILL;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_FILL: begin
        // An abort leaves the partially filled block in place, never flagged valid.
        if (!req) begin
          state_d = S_IDLE;
        end else begin
          block_d[{idx_q, 5'd0} +: 32] = base_q + 32'({idx_q, 2'b00});
          if (idx_q == IDX_LAST) begin
            state_d        = S_RESP;
            ready_d        = 1'b1;
            served_count_d = served_count_q + 16'd1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_RESP: begin
        if (!req) begin
          ready_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign block        = block_q;
  assign block_ready  = ready_q;
  assign busy         = (state_q != S_IDLE);
  assign served_count = served_count_q;

endmodule
